// File: rtl/id_stage.sv
// id_stage: RV32I decode into ID/EX, load-use hold register, post-flush drop.
// Optional: ID_ILLEGAL_TRAP_EN makes ID_illegal a sticky illegal-opcode flag.
//
// Ports:
//   clk, reset (async, active-high)
//   inst_mem_read_data[31:0], IF_take, EX_MEM_flush
//   ID_EX_valid/branch/take/mem_read/mem_write/reg_write
//   ID_EX_imme[31:0], ID_EX_rs1/rs2/rd[4:0], ID_EX_alu_op[3:0]
//   ID_load_use (combinational), ID_illegal
module id_stage #(
  parameter int FLUSH_DROP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_mem_read_data,
  input  logic        IF_take,
  input  logic        EX_MEM_flush,
  output logic        ID_EX_valid,
  output logic        ID_EX_branch,
  output logic        ID_EX_take,
  output logic        ID_EX_mem_read,
  output logic        ID_EX_mem_write,
  output logic        ID_EX_reg_write,
  output logic [31:0] ID_EX_imme,
  output logic [4:0]  ID_EX_rs1,
  output logic [4:0]  ID_EX_rs2,
  output logic [4:0]  ID_EX_rd,
  output logic [3:0]  ID_EX_alu_op,
  output logic        ID_load_use,
  output logic        ID_illegal
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic        branch;
    logic        take;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [31:0] imme;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } idex_t;

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } hold_e;

  hold_e       hold_q, hold_d;
  logic [31:0] hinst_q, hinst_d;
  logic        htake_q, htake_d;
  logic [1:0]  drop_q, drop_d;
  idex_t       idex_q, idex_d, dec;

  logic [31:0] inst;
  logic        take;
  logic        legal;
  logic        use1;
  logic        use2;
  logic        dropping;
  logic        load_use;
  logic        issue;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  f3;

  assign inst = (hold_q == HOLD_FULL) ? hinst_q : inst_mem_read_data;
  assign take = (hold_q == HOLD_FULL) ? htake_q : IF_take;
  assign f3   = inst[14:12];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  // Unused source fields are reported as x0 so they never match a load rd.
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    use1  = 1'b0;
    use2  = 1'b0;
    unique case (1'b1)
      (inst[6:0] == OP_LUI): begin
        dec.imme = imm_u; dec.rd = inst[11:7]; dec.reg_write = 1'b1;
      end
      (inst[6:0] == OP_AUIPC): begin
        dec.imme = imm_u; dec.rd = inst[11:7]; dec.reg_write = 1'b1;
      end
      (inst[6:0] == OP_JAL): begin
        dec.imme = imm_j; dec.rd = inst[11:7]; dec.reg_write = 1'b1;
      end
      (inst[6:0] == OP_JALR): begin
        dec.imme = imm_i; dec.rd = inst[11:7]; dec.reg_write = 1'b1;
        use1 = 1'b1;
      end
      (inst[6:0] == OP_BR): begin
        dec.imme = imm_b; dec.branch = 1'b1;
        dec.alu_op = {1'b0, f3};
        use1 = 1'b1; use2 = 1'b1;
      end
      (inst[6:0] == OP_LOAD): begin
        dec.imme = imm_i; dec.rd = inst[11:7]; dec.reg_write = 1'b1;
        dec.mem_read = 1'b1; use1 = 1'b1;
      end
      (inst[6:0] == OP_STORE): begin
        dec.imme = imm_s; dec.mem_write = 1'b1;
        use1 = 1'b1; use2 = 1'b1;
      end
      (inst[6:0] == OP_IMM): begin
        dec.imme = imm_i; dec.rd = inst[11:7]; dec.reg_write = 1'b1;
        // Only the shift-right group carries funct7[5] (SRAI vs SRLI).
        dec.alu_op = (f3 == 3'b101) ? {inst[30], f3} : {1'b0, f3};
        use1 = 1'b1;
      end
      (inst[6:0] == OP_OP): begin
        dec.rd = inst[11:7]; dec.reg_write = 1'b1;
        dec.alu_op = {inst[30], f3};
        use1 = 1'b1; use2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (use1) dec.rs1 = inst[19:15];
    if (use2) dec.rs2 = inst[24:20];
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    dec.valid = legal;
    dec.take  = take & legal;
  end

  assign dropping = (drop_q != 2'd0);

  assign load_use = !dropping && idex_q.valid && idex_q.mem_read &&
                    (idex_q.rd != 5'd0) &&
                    ((use1 && (dec.rs1 == idex_q.rd)) ||
                     (use2 && (dec.rs2 == idex_q.rd)));

  assign issue = !EX_MEM_flush && !dropping && !load_use;

  always_comb begin
    hold_d  = hold_q;
    hinst_d = hinst_q;
    htake_d = htake_q;
    drop_d  = drop_q;
    idex_d  = '0;
    if (EX_MEM_flush) begin
      hold_d = HOLD_EMPTY;
      drop_d = 2'(FLUSH_DROP);
    end else if (dropping) begin
      drop_d = drop_q - 2'd1;
    end else if (load_use) begin
      hold_d  = HOLD_FULL;
      hinst_d = inst;
      htake_d = take;
    end else begin
      hold_d = HOLD_EMPTY;
      idex_d = dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= HOLD_EMPTY;
      hinst_q <= '0;
      htake_q <= 1'b0;
      drop_q  <= 2'd0;
      idex_q  <= '0;
    end else begin
      hold_q  <= hold_d;
      hinst_q <= hinst_d;
      htake_q <= htake_d;
      drop_q  <= drop_d;
      idex_q  <= idex_d;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;

  assign ill_d = ill_q | (issue & !legal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ill_q <= 1'b0;
    else       ill_q <= ill_d;
  end

  assign ID_illegal = ill_q;
`else
  logic unused_issue;
  assign unused_issue = issue;
  assign ID_illegal   = 1'b0;
`endif

  assign ID_EX_valid     = idex_q.valid;
  assign ID_EX_branch    = idex_q.branch;
  assign ID_EX_take      = idex_q.take;
  assign ID_EX_mem_read  = idex_q.mem_read;
  assign ID_EX_mem_write = idex_q.mem_write;
  assign ID_EX_reg_write = idex_q.reg_write;
  assign ID_EX_imme      = idex_q.imme;
  assign ID_EX_rs1       = idex_q.rs1;
  assign ID_EX_rs2       = idex_q.rs2;
  assign ID_EX_rd        = idex_q.rd;
  assign ID_EX_alu_op    = idex_q.alu_op;
  assign ID_load_use     = load_use;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed + random stimulus against a reference model;
// a scoreboard queue feeds a negedge monitor.
module tb_id_stage;

  localparam int FD = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_mem_read_data = NOP;
  logic        IF_take = 1'b0;
  logic        EX_MEM_flush = 1'b0;
  logic        ID_EX_valid, ID_EX_branch, ID_EX_take;
  logic        ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write;
  logic [31:0] ID_EX_imme;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [3:0]  ID_EX_alu_op;
  logic        ID_load_use, ID_illegal;

  id_stage #(.FLUSH_DROP(FD)) dut (
    .clk(clk), .reset(reset),
    .inst_mem_read_data(inst_mem_read_data),
    .IF_take(IF_take), .EX_MEM_flush(EX_MEM_flush),
    .ID_EX_valid(ID_EX_valid), .ID_EX_branch(ID_EX_branch),
    .ID_EX_take(ID_EX_take), .ID_EX_mem_read(ID_EX_mem_read),
    .ID_EX_mem_write(ID_EX_mem_write),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_imme(ID_EX_imme),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_alu_op(ID_EX_alu_op), .ID_load_use(ID_load_use),
    .ID_illegal(ID_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, branch, take, mr, mw, rw;
    logic [31:0] imme;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        ill;
  } exp_t;

  typedef struct {
    logic rst;
    logic lu;
    exp_t nxt;
  } item_t;

  item_t sbq[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  exp_t        m_prev = '0;
  logic        m_hfull = 1'b0;
  logic [31:0] m_hinst = '0;
  logic        m_htake = 1'b0;
  int          m_drop = 0;
  logic        m_ill = 1'b0;

  function automatic int sx(input logic [31:0] v, input int bits);
    int s;
    s = int'(v);
    if (v[bits-1]) s = s - (1 << bits);
    return s;
  endfunction

  function automatic exp_t decode(input logic [31:0] w, input logic t,
                                  output logic legal,
                                  output logic u1, output logic u2);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] tmp;
    e = '0; legal = 1'b1; u1 = 1'b0; u2 = 1'b0;
    op = w[6:0];
    f3 = w[14:12];
    case (op)
      7'h37, 7'h17: begin
        e.imme = {w[31:12], 12'h000}; e.rd = w[11:7]; e.rw = 1'b1;
      end
      7'h6f: begin
        tmp = {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e.imme = 32'(sx(tmp, 21)); e.rd = w[11:7]; e.rw = 1'b1;
      end
      7'h67: begin
        e.imme = 32'(sx({20'b0, w[31:20]}, 12));
        e.rd = w[11:7]; e.rw = 1'b1; u1 = 1'b1;
      end
      7'h63: begin
        tmp = {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0};
        e.imme = 32'(sx(tmp, 13)); e.branch = 1'b1;
        e.alu = {1'b0, f3}; u1 = 1'b1; u2 = 1'b1;
      end
      7'h03: begin
        e.imme = 32'(sx({20'b0, w[31:20]}, 12));
        e.rd = w[11:7]; e.rw = 1'b1; e.mr = 1'b1; u1 = 1'b1;
      end
      7'h23: begin
        e.imme = 32'(sx({20'b0, w[31:25], w[11:7]}, 12));
        e.mw = 1'b1; u1 = 1'b1; u2 = 1'b1;
      end
      7'h13: begin
        e.imme = 32'(sx({20'b0, w[31:20]}, 12));
        e.rd = w[11:7]; e.rw = 1'b1; u1 = 1'b1;
        e.alu = (f3 == 3'd5) ? {w[30], f3} : {1'b0, f3};
      end
      7'h33: begin
        e.rd = w[11:7]; e.rw = 1'b1; e.alu = {w[30], f3};
        u1 = 1'b1; u2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (u1) e.rs1 = w[19:15];
    if (u2) e.rs2 = w[24:20];
    if (e.rd == 0) e.rw = 1'b0;
    if (legal) begin
      e.valid = 1'b1;
      e.take = t;
    end
    return e;
  endfunction

  task automatic step(input logic [31:0] w, input logic t,
                      input logic f, input logic r);
    item_t it;
    exp_t d;
    logic [31:0] cw;
    logic ct, lg, u1, u2;
    @(posedge clk);
    #1;
    inst_mem_read_data = w;
    IF_take = t;
    EX_MEM_flush = f;
    reset = r;
    it.rst = r;
    it.lu = 1'b0;
    it.nxt = '0;
    if (r) begin
      m_hfull = 1'b0; m_drop = 0; m_ill = 1'b0; m_prev = '0;
    end else begin
      cw = m_hfull ? m_hinst : w;
      ct = m_hfull ? m_htake : t;
      d = decode(cw, ct, lg, u1, u2);
      it.lu = (m_drop == 0) && m_prev.valid && m_prev.mr &&
              (m_prev.rd != 0) &&
              ((u1 && cw[19:15] == m_prev.rd) ||
               (u2 && cw[24:20] == m_prev.rd));
      if (f) begin
        m_hfull = 1'b0; m_drop = FD;
      end else if (m_drop > 0) begin
        m_drop--;
      end else if (it.lu) begin
        m_hfull = 1'b1; m_hinst = cw; m_htake = ct;
      end else begin
        m_hfull = 1'b0;
        if (lg) it.nxt = d;
`ifdef ID_ILLEGAL_TRAP_EN
        else m_ill = 1'b1;
`endif
      end
      it.nxt.ill = m_ill;
      m_prev = it.nxt;
    end
    sbq.push_back(it);
  endtask

  exp_t pend = '0;

  always @(negedge clk) begin
    item_t it;
    exp_t got, want;
    if (sbq.size() > 0) begin
      it = sbq.pop_front();
      want = it.rst ? exp_t'(0) : pend;
      got = {ID_EX_valid, ID_EX_branch, ID_EX_take, ID_EX_mem_read,
             ID_EX_mem_write, ID_EX_reg_write, ID_EX_imme, ID_EX_rs1,
             ID_EX_rs2, ID_EX_rd, ID_EX_alu_op, ID_illegal};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL idex t=%0t got=%h want=%h", $time, got, want);
      end
      checks++;
      if (ID_load_use !== it.lu) begin
        errors++;
        $display("FAIL load_use t=%0t got=%b want=%b",
                 $time, ID_load_use, it.lu);
      end
      pend = it.nxt;
    end
  end

  initial begin
    logic [6:0] ops [10];
    logic [31:0] w;
    int r;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
            7'h03, 7'h23, 7'h13, 7'h33, 7'h00};

    step(NOP, 1'b0, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b1);
    // beq x1,x2,+8 predicted taken
    step(32'h0020_8463, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);
    // lw x5 then dependent add
    step(32'h0000_A283, 1'b0, 1'b0, 1'b0);
    step(32'h0012_8333, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);
    // flush: next word dropped, following issued
    step(32'h0050_0093, 1'b0, 1'b1, 1'b0);
    step(32'h0050_0093, 1'b0, 1'b0, 1'b0);
    step(32'h0060_0113, 1'b0, 1'b0, 1'b0);
    // flush coincident with load-use
    step(32'h0000_A283, 1'b0, 1'b0, 1'b0);
    step(32'h0012_8333, 1'b0, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);
    step(32'h0012_8333, 1'b0, 1'b0, 1'b0);
    // flush during drop reloads the counter
    step(NOP, 1'b0, 1'b1, 1'b0);
    step(NOP, 1'b0, 1'b1, 1'b0);
    step(32'h0050_0093, 1'b0, 1'b0, 1'b0);
    step(32'h0060_0113, 1'b0, 1'b0, 1'b0);
    // illegal opcode
    step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);
    // reset while HELD
    step(32'h0000_A283, 1'b0, 1'b0, 1'b0);
    step(32'h0012_8333, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b1);
    step(32'h0050_0093, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      step(w, 1'($urandom), (r < 8), (r == 99));
    end
    step(NOP, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter FLUSH_DROP, default 1: number of fetched instructions discarded after EX_MEM_flush, 0..3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inst_mem_read_data  input  32  instruction word returned for the previous cycle's inst_mem_read_addr.
REQ-005 IF_take  input  1  prediction taken by fetch for this instruction.
REQ-006 EX_MEM_flush  input  1  misprediction flush from EX/MEM.
REQ-007 ID_EX_valid, ID_EX_branch, ID_EX_take, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write  output  1 each  ID/EX control bits; ID_EX_branch is set only for conditional branches (opcode 1100011).
REQ-008 ID_EX_imme  output  32  sign-extended immediate.
REQ-009 ID_EX_rs1, ID_EX_rs2, ID_EX_rd  output  5 each  register indices.
REQ-010 ID_EX_alu_op  output  4  ALU selector.
REQ-011 ID_load_use  output  1  combinational load-use hazard; drives EX_MEM_stall.
REQ-012 ID_illegal  output  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-013 Decode is combinational from the selected instruction source; results register into ID/EX on the next rising edge (1-cycle latency).
REQ-014 Immediates: I, S, B, U and J formats per RV32I, sign-extended from bit 31; R-type yields 0.
REQ-015 alu_op = {funct7[5],funct3} for R-type and SRAI; {0,funct3} for other OP-IMM; 0000 for load, store, LUI, AUIPC, JAL, JALR; {0,funct3} for branches.
REQ-016 rd is forced to 0 and reg_write to 0 for store and branch; reg_write to 0 whenever decoded rd == 0.
REQ-017 Load-use: ID_load_use = 1 when ID_EX_valid & ID_EX_mem_read & ID_EX_rd != 0 & ID_EX_rd equals the used rs1 or rs2 of the current instruction.
REQ-018 On load-use: ID/EX loads a bubble (all control bits 0, valid 0); the current instruction and IF_take are captured in a hold register; next cycle decodes from the hold register instead of inst_mem_read_data.
REQ-019 Hold register is a one-entry state: EMPTY -> HELD on load-use; HELD -> EMPTY once its instruction is issued into ID/EX; HELD stays HELD while the hazard persists.
REQ-020 On EX_MEM_flush: ID/EX loads a bubble, hold register empties, drop counter loads FLUSH_DROP.
REQ-021 While drop counter is nonzero, each cycle decrements it and the incoming word is replaced by a bubble; load-use is not evaluated on a dropped word.
REQ-022 EX_MEM_flush and load-use in the same cycle: flush wins.
REQ-023 EX_MEM_flush during a nonzero drop count reloads FLUSH_DROP.
REQ-024 ID_EX_take carries IF_take (or the held copy) of the issued instruction.

Reset
REQ-025 reset clears all ID/EX outputs to 0, hold register to EMPTY, drop counter to 0, ID_illegal to 0.
REQ-026 reset asserted mid-stall or mid-drop abandons that state; first post-reset word is decoded normally.

Configuration
REQ-027 Macro ID_ILLEGAL_TRAP_EN defined: opcodes outside RV32I base set (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP) issue a bubble and set ID_illegal, sticky until reset.
REQ-028 Macro ID_ILLEGAL_TRAP_EN undefined: illegal opcodes issue a bubble, ID_illegal is tied 0.

Verification
REQ-029 0x00208463 (beq x1,x2,+8), IF_take=1 -> next cycle ID_EX_branch=1, ID_EX_imme=8, rs1=1, rs2=2, ID_EX_take=1, reg_write=0.
REQ-030 0x0000A283 (lw x5,0(x1)) then 0x00128333 (add x6,x5,x1) -> ID_load_use=1 one cycle, one bubble, then add issued with rd=6, alu_op=0000, reg_write=1.
REQ-031 EX_MEM_flush with FLUSH_DROP=1 -> bubble that cycle, next word dropped, following word issued.
REQ-032 EX_MEM_flush coincident with load-use -> bubble, hold register EMPTY, ID_load_use ignored by state.
REQ-033 0xFFFFFFFF with ID_ILLEGAL_TRAP_EN -> bubble, ID_illegal=1 held until reset; without macro -> bubble, ID_illegal=0.
REQ-034 reset pulse while HELD -> all outputs 0, next word 0x00500093 (addi x1,x0,5) issues imme=5, rd=1.
